// File: rtl/spi_burst_fifo.sv
// spi_burst_fifo: buffered SPI master (mode 3, MSB first) with TX and RX byte FIFOs.
// The CPU side pushes bytes into TX and pops received bytes from RX. The shift engine
// runs gapless back-to-back bytes while ss_en is high and TX holds data.
// Ports:
//   CLK1, RST_N           clock, asynchronous active-low reset
//   ss_en                 request chip select; SS only rises between bytes
//   rx_capture            1: store received bytes in RX, 0: discard them
//   tx_data, tx_push      TX write port; tx_full, tx_count report occupancy
//   rx_data, rx_pop       RX read port (first-word-fall-through); rx_empty status
//   rx_overflow           sticky, set when a received byte is dropped on a full RX
//   busy                  engine active or TX non-empty
//   SPI_SCK/SDO/SDI/SS    serial pins (SCK and SDO idle high, SS active low)
// Optional feature (macro SPI_CMD_GUARD_EN): adds output guard_trip and refuses
// dual/quad opcodes as the first byte after SS falls.
module spi_burst_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DIV   = 1
) (
  input  logic                   CLK1,
  input  logic                   RST_N,
  input  logic                   ss_en,
  input  logic                   rx_capture,
  input  logic [7:0]             tx_data,
  input  logic                   tx_push,
  output logic                   tx_full,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [7:0]             rx_data,
  input  logic                   rx_pop,
  output logic                   rx_empty,
  output logic                   rx_overflow,
  output logic                   busy,
  output logic                   SPI_SCK,
  output logic                   SPI_SDO,
  input  logic                   SPI_SDI,
  output logic                   SPI_SS
`ifdef SPI_CMD_GUARD_EN
  ,
  output logic                   guard_trip
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t      state;
  logic [6:0]  tx_shift;     // bits still to send after the one on SDO
  logic [7:0]  rx_shift;
  logic [2:0]  bit_cnt;
  logic [7:0]  div_cnt;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [CW-1:0] rx_cnt;

  logic [7:0] tx_head_c;
  logic       tx_empty_c, tx_push_ok_c, tx_pop_c, tx_flush_c;
  logic       rx_full_c, rx_pop_ok_c, rx_wr_c, rx_wr_ok_c;
  logic       div_done_c, idle_go_c, setup_c, start_c, next_c, guard_hit_c;

`ifdef SPI_CMD_GUARD_EN
  logic first_byte;
  logic guard_lock;

  // Dual/quad read/program opcodes the single-line flash path must never issue.
  function automatic logic is_forbidden(input logic [7:0] op);
    case (op)
      8'h3B, 8'h6B, 8'hEB, 8'hBB, 8'h77, 8'h32, 8'h92, 8'h94: is_forbidden = 1'b1;
      default:                                               is_forbidden = 1'b0;
    endcase
  endfunction
`endif

  assign tx_count    = tx_cnt;
  assign tx_full     = (tx_cnt == CW'(DEPTH));
  assign rx_empty    = (rx_cnt == '0);
  assign rx_data     = rx_mem[rx_rptr];
  assign busy        = (state != IDLE) || (tx_cnt != '0);

  // Engine handshakes and FIFO strobes.
  always_comb begin
    tx_empty_c  = (tx_cnt == '0);
    tx_head_c   = tx_mem[tx_rptr];
    div_done_c  = (div_cnt == DIV_LAST);
    idle_go_c   = (state == IDLE) && ss_en && !tx_empty_c;
`ifdef SPI_CMD_GUARD_EN
    idle_go_c   = idle_go_c && !guard_lock;
`endif
    // SS still high: spend one setup cycle dropping it before the first LOW.
    setup_c     = idle_go_c && SPI_SS;
    start_c     = idle_go_c && !SPI_SS;
    next_c      = (state == DONE) && ss_en && !tx_empty_c;
`ifdef SPI_CMD_GUARD_EN
    guard_hit_c = start_c && first_byte && is_forbidden(tx_head_c);
`else
    guard_hit_c = 1'b0;
`endif
    tx_flush_c   = guard_hit_c;
    tx_pop_c     = (start_c && !guard_hit_c) || next_c;
    // A push on a full FIFO is accepted only if the engine frees a slot this cycle.
    tx_push_ok_c = tx_push && !tx_flush_c && (!tx_full || tx_pop_c);
    rx_full_c    = (rx_cnt == CW'(DEPTH));
    rx_pop_ok_c  = rx_pop && !rx_empty;
    rx_wr_c      = (state == DONE) && rx_capture;
    rx_wr_ok_c   = rx_wr_c && (!rx_full_c || rx_pop_ok_c);
  end

  // Shift engine: IDLE -> LOW/HIGH x8 -> DONE, with registered pin outputs.
  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      SPI_SCK  <= 1'b1;
      SPI_SDO  <= 1'b1;
      SPI_SS   <= 1'b1;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          SPI_SCK <= 1'b1;
          SPI_SDO <= 1'b1;
          if (!ss_en) begin
            SPI_SS <= 1'b1;
          end else if (setup_c) begin
            SPI_SS <= 1'b0;
          end else if (guard_hit_c) begin
            SPI_SS <= 1'b1;
          end else if (start_c) begin
            tx_shift <= tx_head_c[6:0];
            SPI_SDO  <= tx_head_c[7];
            SPI_SCK  <= 1'b0;
            bit_cnt  <= 3'd7;
            div_cnt  <= '0;
            state    <= LOW;
          end
        end
        LOW: begin
          if (div_done_c) begin
            div_cnt  <= '0;
            SPI_SCK  <= 1'b1;
            rx_shift <= {rx_shift[6:0], SPI_SDI};
            state    <= HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HIGH: begin
          if (div_done_c) begin
            div_cnt <= '0;
            if (bit_cnt == 3'd0) begin
              state <= DONE;
            end else begin
              bit_cnt  <= bit_cnt - 3'd1;
              SPI_SDO  <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
              SPI_SCK  <= 1'b0;
              state    <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          if (next_c) begin
            tx_shift <= tx_head_c[6:0];
            SPI_SDO  <= tx_head_c[7];
            SPI_SCK  <= 1'b0;
            bit_cnt  <= 3'd7;
            div_cnt  <= '0;
            state    <= LOW;
          end else begin
            SPI_SDO <= 1'b1;
            state   <= IDLE;
            if (!ss_en) SPI_SS <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
    end else if (tx_flush_c) begin
      tx_rptr <= tx_wptr;
      tx_cnt  <= '0;
    end else begin
      if (tx_push_ok_c) tx_wptr <= tx_wptr + AW'(1);
      if (tx_pop_c)     tx_rptr <= tx_rptr + AW'(1);
      case ({tx_push_ok_c, tx_pop_c})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK1) begin
    if (tx_push_ok_c) tx_mem[tx_wptr] <= tx_data;
  end

  // RX FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      rx_wptr     <= '0;
      rx_rptr     <= '0;
      rx_cnt      <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_wr_ok_c)  rx_wptr <= rx_wptr + AW'(1);
      if (rx_pop_ok_c) rx_rptr <= rx_rptr + AW'(1);
      if (rx_wr_c && !rx_wr_ok_c) rx_overflow <= 1'b1;
      case ({rx_wr_ok_c, rx_pop_ok_c})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK1) begin
    if (rx_wr_ok_c) rx_mem[rx_wptr] <= rx_shift;
  end

`ifdef SPI_CMD_GUARD_EN
  // Opcode guard: arm on SS fall, lock out until ss_en is dropped after a trip.
  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      first_byte <= 1'b0;
      guard_lock <= 1'b0;
      guard_trip <= 1'b0;
    end else begin
      if (setup_c)                      first_byte <= 1'b1;
      else if (tx_pop_c || guard_hit_c) first_byte <= 1'b0;
      if (guard_hit_c) begin
        guard_lock <= 1'b1;
        guard_trip <= 1'b1;
      end else if ((state == IDLE) && !ss_en) begin
        guard_lock <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_burst_fifo.sv
// tb_spi_burst_fifo: randomized scoreboard bench for spi_burst_fifo.
// Expected SDO bytes and RX bytes are queued when stimulus is issued; independent
// monitors pop and compare when the DUT shows a completed byte or a non-empty RX.
module tb_spi_burst_fifo;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned DIV      = 1;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int          BYTE_CYC = 16 * DIV + 1;

  logic          CLK1 = 1'b0;
  logic          RST_N = 1'b0;
  logic          ss_en = 1'b0;
  logic          rx_capture = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_push = 1'b0;
  logic          tx_full;
  logic [CW-1:0] tx_count;
  logic [7:0]    rx_data;
  logic          rx_pop = 1'b0;
  logic          rx_empty;
  logic          rx_overflow;
  logic          busy;
  logic          SPI_SCK;
  logic          SPI_SDO;
  logic          SPI_SDI;
  logic          SPI_SS;
`ifdef SPI_CMD_GUARD_EN
  logic          guard_trip;
`endif

  logic sdi_loop = 1'b0;   // 1: SDI looped to SDO, 0: SDI tied high
  logic pop_en   = 1'b0;
  assign SPI_SDI = sdi_loop ? SPI_SDO : 1'b1;

  spi_burst_fifo #(.DEPTH(DEPTH), .DIV(DIV)) dut (
    .CLK1(CLK1), .RST_N(RST_N), .ss_en(ss_en), .rx_capture(rx_capture),
    .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full), .tx_count(tx_count),
    .rx_data(rx_data), .rx_pop(rx_pop), .rx_empty(rx_empty), .rx_overflow(rx_overflow),
    .busy(busy), .SPI_SCK(SPI_SCK), .SPI_SDO(SPI_SDO), .SPI_SDI(SPI_SDI), .SPI_SS(SPI_SS)
`ifdef SPI_CMD_GUARD_EN
    , .guard_trip(guard_trip)
`endif
  );

  initial forever #5 CLK1 = ~CLK1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = 8'($urandom);
    case (b)
      8'h3B, 8'h6B, 8'hEB, 8'hBB, 8'h77, 8'h32, 8'h92, 8'h94: b = b ^ 8'h01;
      default: ;
    endcase
    return b;
  endfunction

  // SDO monitor: one bit per SCK rise, MSB first, compared per completed byte.
  logic       prev_sck = 1'b1;
  logic [7:0] mon_byte = 8'h00;
  int         mon_bits = 0;
  int         sck_rises = 0;
  int         bytes_seen = 0;
  always @(negedge CLK1) begin
    if (!RST_N) begin
      mon_bits = 0;
      prev_sck = 1'b1;
    end else begin
      if (!prev_sck && SPI_SCK) begin
        sck_rises++;
        mon_byte = {mon_byte[6:0], SPI_SDO};
        mon_bits++;
        if (mon_bits == 8) begin
          mon_bits = 0;
          bytes_seen++;
          if (exp_tx.size() == 0) check("sdo_unexpected_byte", int'(mon_byte), 256);
          else check("sdo_byte", int'(mon_byte), int'(exp_tx.pop_front()));
        end
      end
      prev_sck = SPI_SCK;
    end
  end

  // RX monitor: randomly pops a non-empty RX and compares the head.
  initial begin : rx_mon
    forever begin
      @(negedge CLK1);
      rx_pop = 1'b0;
      if (RST_N && pop_en && !rx_empty && ($urandom_range(0, 1) == 1)) begin
        if (exp_rx.size() == 0) check("rx_unexpected_byte", int'(rx_data), 256);
        else check("rx_data", int'(rx_data), int'(exp_rx.pop_front()));
        rx_pop = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b);
    tx_data = b;
    tx_push = 1'b1;
    @(negedge CLK1);
    tx_push = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge CLK1);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic wait_rx_drain(input string name, input int budget);
    int n = 0;
    while (exp_rx.size() != 0 && n < budget) begin
      @(negedge CLK1);
      n++;
    end
    check(name, exp_rx.size(), 0);
  endtask

  initial begin : main
    int n, ss_low, r0, b0;
    logic [7:0] b;

    // Reset values
    repeat (2) @(negedge CLK1);
    check("rst_tx_full", int'(tx_full), 0);
    check("rst_tx_count", int'(tx_count), 0);
    check("rst_rx_empty", int'(rx_empty), 1);
    check("rst_rx_overflow", int'(rx_overflow), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sck", int'(SPI_SCK), 1);
    check("rst_sdo", int'(SPI_SDO), 1);
    check("rst_ss", int'(SPI_SS), 1);
`ifdef SPI_CMD_GUARD_EN
    check("rst_guard_trip", int'(guard_trip), 0);
`endif
    RST_N = 1'b1;
    repeat (2) @(negedge CLK1);

    // Single byte A5, SDI high; ss_en dropped mid-byte so SS closes after it
    sdi_loop = 1'b0; rx_capture = 1'b1; pop_en = 1'b1; ss_en = 1'b1;
    exp_tx.push_back(8'hA5); exp_rx.push_back(8'hFF);
    push(8'hA5);
    ss_low = 0; n = 0;
    while (n < 200) begin
      if (!SPI_SS) ss_low++;
      if (ss_low == 3) ss_en = 1'b0;
      if (ss_low > 0 && SPI_SS) break;
      @(negedge CLK1);
      n++;
    end
    check("ss_low_cycles", ss_low, 2 + 16 * DIV);
    wait_idle("a5_idle", 100);
    wait_rx_drain("a5_rx_drain", 100);

    // Gapless 4-byte burst, loopback
    sdi_loop = 1'b1;
    foreach (exp_tx[i]) ;
    begin
      logic [7:0] burst[4];
      burst[0] = 8'h03; burst[1] = 8'h00; burst[2] = 8'h00; burst[3] = 8'h00;
      for (int i = 0; i < 4; i++) begin
        exp_tx.push_back(burst[i]); exp_rx.push_back(burst[i]);
        push(burst[i]);
      end
    end
    ss_en = 1'b1;
    n = 0;
    do begin
      @(negedge CLK1);
      if (busy) n++;
    end while (busy && n < 500);
    check("burst_busy_cycles", n, 1 + 4 * BYTE_CYC);
    ss_en = 1'b0;
    wait_rx_drain("burst_rx_drain", 200);

    // Random loopback bursts, pushes issued while the engine runs
    for (int r = 0; r < 4; r++) begin
      ss_en = 1'b1;
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
        b = rand_byte();
        exp_tx.push_back(b); exp_rx.push_back(b);
        push(b);
        repeat ($urandom_range(0, 20)) @(negedge CLK1);
      end
      wait_idle("rand_idle", 8 * BYTE_CYC + 20);
      ss_en = 1'b0;
      wait_rx_drain("rand_rx_drain", 200);
      @(negedge CLK1);
    end

    // TX fill to DEPTH with ss_en low; extra push ignored
    rx_capture = 1'b0;
    for (int k = 0; k < int'(DEPTH) + 1; k++) begin
      b = rand_byte();
      if (k < int'(DEPTH)) exp_tx.push_back(b);
      push(b);
      if (k == 0) check("fill_count_1", int'(tx_count), 1);
      if (k == int'(DEPTH) - 2) check("fill_not_full", int'(tx_full), 0);
      if (k == int'(DEPTH) - 1) check("fill_full", int'(tx_full), 1);
    end
    check("fill_count_depth", int'(tx_count), int'(DEPTH));
    check("fill_still_full", int'(tx_full), 1);
    b0 = bytes_seen;
    ss_en = 1'b1;
    @(negedge CLK1);
    wait_idle("fill_idle", int'(DEPTH) * BYTE_CYC + 20);
    check("fill_bytes_sent", bytes_seen - b0, int'(DEPTH));
    check("fill_rx_discarded", int'(rx_empty), 1);
    ss_en = 1'b0;
    repeat (2) @(negedge CLK1);

    // RX overflow: DEPTH+1 bytes received, never popped
    rx_capture = 1'b1; pop_en = 1'b0; sdi_loop = 1'b1;
    for (int k = 0; k < int'(DEPTH); k++) begin
      b = rand_byte();
      exp_tx.push_back(b); exp_rx.push_back(b);
      push(b);
    end
    ss_en = 1'b1;
    n = 0;
    while (tx_full && n < 100) begin
      @(negedge CLK1);
      n++;
    end
    check("ovf_slot_freed", int'(tx_full), 0);
    b = rand_byte();
    exp_tx.push_back(b);
    push(b);
    wait_idle("ovf_idle", (int'(DEPTH) + 1) * BYTE_CYC + 20);
    check("ovf_sticky", int'(rx_overflow), 1);
    check("ovf_rx_nonempty", int'(rx_empty), 0);
    ss_en = 1'b0;
    pop_en = 1'b1;
    wait_rx_drain("ovf_rx_drain", 400);
    repeat (2) @(negedge CLK1);
    check("ovf_rx_empty_after", int'(rx_empty), 1);
    check("ovf_still_sticky", int'(rx_overflow), 1);

    // ss_en dropped mid-byte: byte completes before SS rises
    rx_capture = 1'b0;
    b = rand_byte();
    exp_tx.push_back(b);
    push(b);
    ss_en = 1'b1;
    n = 0;
    while (SPI_SCK && n < 20) begin
      @(negedge CLK1);
      n++;
    end
    ss_en = 1'b0;
    r0 = sck_rises;
    n = 0;
    while (!SPI_SS && n < 100) begin
      @(negedge CLK1);
      n++;
    end
    check("drop_rises_before_ss", sck_rises - r0, 8);
    check("drop_tx_sent", exp_tx.size(), 0);

    // Asynchronous reset mid-byte
    for (int k = 0; k < 2; k++) push(rand_byte());
    ss_en = 1'b1;
    r0 = sck_rises;
    n = 0;
    while (sck_rises < r0 + 3 && n < 50) begin
      @(negedge CLK1);
      n++;
    end
    exp_tx.delete(); exp_rx.delete();
    #2 RST_N = 1'b0;
    #1;
    check("arst_ss", int'(SPI_SS), 1);
    check("arst_sck", int'(SPI_SCK), 1);
    check("arst_tx_count", int'(tx_count), 0);
    check("arst_rx_empty", int'(rx_empty), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_overflow_clr", int'(rx_overflow), 0);
    ss_en = 1'b0;
    @(negedge CLK1);
    @(negedge CLK1);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK1);

`ifdef SPI_CMD_GUARD_EN
    // Guard: forbidden first opcode flushes TX and locks until ss_en toggles
    push(8'h6B);
    push(8'h01);
    r0 = sck_rises;
    ss_en = 1'b1;
    repeat (20) @(negedge CLK1);
    check("guard_no_sck", sck_rises - r0, 0);
    check("guard_trip_set", int'(guard_trip), 1);
    check("guard_tx_flushed", int'(tx_count), 0);
    check("guard_ss_high", int'(SPI_SS), 1);
    push(8'h9F);
    repeat (20) @(negedge CLK1);
    check("guard_locked_count", int'(tx_count), 1);
    check("guard_locked_no_sck", sck_rises - r0, 0);
    ss_en = 1'b0;
    repeat (2) @(negedge CLK1);
    exp_tx.push_back(8'h9F);
    ss_en = 1'b1;
    @(negedge CLK1);
    wait_idle("guard_resume_idle", BYTE_CYC + 20);
    check("guard_resume_sent", exp_tx.size(), 0);
    check("guard_trip_sticky", int'(guard_trip), 1);
    ss_en = 1'b0;
    repeat (2) @(negedge CLK1);
`endif

    check("end_tx_queue_empty", exp_tx.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
